// File: rtl/link_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | link_pkg : word/counter types and FSM states shared by link tx and rx;    |
// | ST_GAP exists only with LINK_TX_GAP_EN.          Revision 1.0             |
// +--------------------------------------------------------------------------+
package link_pkg;

  localparam int LINK_WORD_W = 16;
  localparam int LINK_CNT_W  = 4;

  // Index 0 of a link word is the first bit on the wire.
  typedef logic [0:LINK_WORD_W-1] link_word_t;
  typedef logic [LINK_CNT_W-1:0]  link_cnt_t;

  localparam link_cnt_t CNT_PRELAST = link_cnt_t'(LINK_WORD_W - 2);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1
`ifdef LINK_TX_GAP_EN
    , ST_GAP = 2'd2
`endif
  } link_state_e;

endpackage
`default_nettype wire

// File: rtl/link_tx_shifter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | link_tx_shifter : serialising shift register with bit counter and        |
// | registered last-bit flag.                        Revision 1.0             |
// +--------------------------------------------------------------------------+
module link_tx_shifter
  import link_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       shift,
  input  link_word_t word,
  output logic       s_out,
  output logic       last
);

  link_word_t sreg_q, sreg_d;
  link_cnt_t  cnt_q,  cnt_d;
  logic       last_q, last_d;

  // Zeros are shifted in, so one flush shift after bit 15 leaves the line low.
  always_comb begin
    sreg_d = sreg_q;
    cnt_d  = cnt_q;
    last_d = 1'b0;
    if (load) begin
      sreg_d = word;
      cnt_d  = '0;
    end else if (shift) begin
      sreg_d = {sreg_q[1:LINK_WORD_W-1], 1'b0};
      cnt_d  = cnt_q + link_cnt_t'(1);
      last_d = (cnt_q == CNT_PRELAST);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg_q <= '0;
      cnt_q  <= '0;
      last_q <= 1'b0;
    end else begin
      sreg_q <= sreg_d;
      cnt_q  <= cnt_d;
      last_q <= last_d;
    end
  end

  assign s_out = sreg_q[0];
  assign last  = last_q;

endmodule
`default_nettype wire

// File: rtl/link_transmitter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | link_transmitter : holding register + FSM feeding link_tx_shifter;       |
// | LINK_TX_GAP_EN inserts GAP_CYCLES idle cycles between frames. Rev 1.0    |
// +--------------------------------------------------------------------------+
module link_transmitter
  import link_pkg::*;
#(
  parameter int GAP_CYCLES = 1
)
(
  input  logic                   LINK_CLK,
  input  logic                   RESETN,
  input  logic [0:LINK_WORD_W-1] DATA_IN,
  input  logic                   SEND,
  output logic                   READY,
  output logic                   S_OUT,
  output logic                   SYNC,
  output logic                   FRAME_DONE
);

  if (GAP_CYCLES < 1 || GAP_CYCLES > 15) begin : g_gap_cycles_check
    $error("link_transmitter: GAP_CYCLES must be in 1..15");
  end

  link_state_e state_q, state_d;
  link_word_t  hold_q, hold_d;
  logic        valid_q, valid_d;
  logic        frame_done_q, frame_done_d;
  logic        load, shift, last;

`ifdef LINK_TX_GAP_EN
  localparam link_cnt_t GAP_LAST = link_cnt_t'(GAP_CYCLES - 1);
  link_cnt_t gap_cnt_q, gap_cnt_d;
`endif

  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    valid_d      = valid_q;
    load         = 1'b0;
    shift        = 1'b0;
    frame_done_d = last;
`ifdef LINK_TX_GAP_EN
    gap_cnt_d    = gap_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (valid_q) begin
          load    = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (!last) begin
          shift = 1'b1;
`ifdef LINK_TX_GAP_EN
        end else begin
          shift     = 1'b1;
          gap_cnt_d = '0;
          state_d   = ST_GAP;
        end
`else
        end else if (valid_q) begin
          load = 1'b1;
        end else begin
          shift   = 1'b1;
          state_d = ST_IDLE;
        end
`endif
      end
`ifdef LINK_TX_GAP_EN
      ST_GAP: begin
        gap_cnt_d = gap_cnt_q + link_cnt_t'(1);
        if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d = '0;
          if (valid_q) begin
            load    = 1'b1;
            state_d = ST_SHIFT;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    // READY is ~valid, so a transfer and an accept never share an edge.
    if (load) begin
      valid_d = 1'b0;
    end else if (SEND && !valid_q) begin
      valid_d = 1'b1;
      hold_d  = DATA_IN;
    end
  end

  always_ff @(posedge LINK_CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q      <= ST_IDLE;
      hold_q       <= '0;
      valid_q      <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      valid_q      <= valid_d;
      frame_done_q <= frame_done_d;
    end
  end

`ifdef LINK_TX_GAP_EN
  always_ff @(posedge LINK_CLK or negedge RESETN) begin
    if (!RESETN) begin
      gap_cnt_q <= '0;
    end else begin
      gap_cnt_q <= gap_cnt_d;
    end
  end
`endif

  link_tx_shifter u_shifter (
    .clk   (LINK_CLK),
    .rst_n (RESETN),
    .load  (load),
    .shift (shift),
    .word  (hold_q),
    .s_out (S_OUT),
    .last  (last)
  );

  assign READY      = ~valid_q;
  assign SYNC       = last;
  assign FRAME_DONE = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_link_transmitter.sv
`default_nettype none
// tb_link_transmitter : directed checks of link_transmitter framing, handshake,
// reset abort and a loopback receiver model.
module tb_link_transmitter;

  localparam int GAP = 3;
`ifdef LINK_TX_GAP_EN
  localparam int EXP_GAP = GAP;
`else
  localparam int EXP_GAP = 0;
`endif

  logic        clk  = 1'b0;
  logic        rstn = 1'b0;
  logic        send = 1'b0;
  logic [0:15] din  = '0;
  logic        ready, s_out, sync, fdone;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  link_transmitter #(.GAP_CYCLES(GAP)) dut (
    .LINK_CLK   (clk),
    .RESETN     (rstn),
    .DATA_IN    (din),
    .SEND       (send),
    .READY      (ready),
    .S_OUT      (s_out),
    .SYNC       (sync),
    .FRAME_DONE (fdone)
  );

  // Receiver model: the 16 bits ending on a SYNC cycle form one word.
  logic [0:15] rx_sr = '0;
  logic [0:15] rx_words[$];
  int          fd_count = 0;

  always @(negedge clk) begin
    if (rstn) begin
      if (sync) rx_words.push_back({rx_sr[1:15], s_out});
      rx_sr <= {rx_sr[1:15], s_out};
      if (fdone) fd_count++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    send = 1'b0;
    #3;
    n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", ready); end
    n_tests++; if (s_out !== 1'b0) begin n_fail++; $display("FAIL reset_sout: got %b want 0", s_out); end
    n_tests++; if (sync  !== 1'b0) begin n_fail++; $display("FAIL reset_sync: got %b want 0", sync); end
    n_tests++; if (fdone !== 1'b0) begin n_fail++; $display("FAIL reset_fdone: got %b want 0", fdone); end
    tick();
    tick();
    rstn = 1'b1;
    tick();
    n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b want 1", ready); end
  endtask

  task automatic test_single(input logic [0:15] w, input string name);
    send = 1'b1;
    din  = w;
    tick();
    send = 1'b0;
    din  = '0;
    n_tests++; if (ready !== 1'b0) begin n_fail++; $display("FAIL %s_ready: got %b want 0", name, ready); end
    tick();
    for (int k = 0; k < 16; k++) begin
      n_tests++; if (s_out !== w[k]) begin n_fail++; $display("FAIL %s_bit%0d: got %b want %b", name, k, s_out, w[k]); end
      n_tests++; if (sync !== 1'(k == 15)) begin n_fail++; $display("FAIL %s_sync%0d: got %b want %b", name, k, sync, (k == 15)); end
      n_tests++; if (fdone !== 1'b0) begin n_fail++; $display("FAIL %s_fdone_early%0d: got %b want 0", name, k, fdone); end
      tick();
    end
    n_tests++;
    if ({fdone, sync, s_out} !== 3'b100) begin
      n_fail++; $display("FAIL %s_done: got fd/sync/sout=%b%b%b want 100", name, fdone, sync, s_out);
    end
    tick();
    n_tests++; if (fdone !== 1'b0) begin n_fail++; $display("FAIL %s_done_pulse: got %b want 0", name, fdone); end
  endtask

  task automatic test_back_to_back();
    logic [0:15] w1 = 16'hFFFF;
    logic [0:15] w2 = 16'h0001;
    int          n  = 34 + EXP_GAP;
    logic        es, ey, ef;
    send = 1'b1;
    din  = w1;
    tick();
    n_tests++; if (ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_held: got %b want 0", ready); end
    din = w2;
    tick();
    n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_free: got %b want 1", ready); end
    for (int c = 0; c < n; c++) begin
      es = 1'b0; ey = 1'b0;
      if (c < 16) begin
        es = w1[c]; ey = (c == 15);
      end else if (c >= 16 + EXP_GAP && c < 32 + EXP_GAP) begin
        es = w2[c - 16 - EXP_GAP]; ey = (c == 31 + EXP_GAP);
      end
      ef = (c == 16) || (c == 32 + EXP_GAP);
      n_tests++; if (s_out !== es) begin n_fail++; $display("FAIL b2b_sout c%0d: got %b want %b", c, s_out, es); end
      n_tests++; if (sync  !== ey) begin n_fail++; $display("FAIL b2b_sync c%0d: got %b want %b", c, sync, ey); end
      n_tests++; if (fdone !== ef) begin n_fail++; $display("FAIL b2b_fdone c%0d: got %b want %b", c, fdone, ef); end
      if (c == 1) begin
        n_tests++; if (ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_second: got %b want 0", ready); end
      end
      tick();
      if (c == 0) send = 1'b0;
    end
  endtask

  task automatic test_ignore();
    logic [0:15] wa = 16'h8421;
    logic [0:15] wb = 16'h0F0F;
    logic [0:15] wx = 16'h1234;
    int          n  = 34 + EXP_GAP;
    int          stray = 0;
    logic        es;
    send = 1'b1;
    din  = wa;
    tick();
    din = wx;
    tick();
    for (int c = 0; c < n; c++) begin
      es = 1'b0;
      if (c < 16) es = wa[c];
      else if (c >= 16 + EXP_GAP && c < 32 + EXP_GAP) es = wb[c - 16 - EXP_GAP];
      n_tests++; if (s_out !== es) begin n_fail++; $display("FAIL ign_sout c%0d: got %b want %b", c, s_out, es); end
      if (c >= 1 && c <= 10) begin
        n_tests++; if (ready !== 1'b0) begin n_fail++; $display("FAIL ign_ready c%0d: got %b want 0", c, ready); end
      end
      if (c == 0)      din  = wb;
      else if (c == 1) din  = wx;
      else if (c == 11) send = 1'b0;
      tick();
    end
    for (int c = 0; c < 20; c++) begin
      if (s_out !== 1'b0 || sync !== 1'b0) stray++;
      tick();
    end
    n_tests++; if (stray != 0) begin n_fail++; $display("FAIL ign_no_third_frame: got %0d active cycles want 0", stray); end
  endtask

  task automatic test_reset_mid();
    logic [0:15] w = 16'hBEEF;
    int          bad = 0;
    send = 1'b1;
    din  = w;
    tick();
    din = 16'h1357;
    tick();
    tick();
    send = 1'b0;
    n_tests++; if (ready !== 1'b0) begin n_fail++; $display("FAIL rmid_held: got %b want 0", ready); end
    repeat (6) tick();
    n_tests++; if (s_out !== w[7]) begin n_fail++; $display("FAIL rmid_bit7: got %b want %b", s_out, w[7]); end
    #2;
    rstn = 1'b0;
    #1;
    n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL rmid_ready: got %b want 1", ready); end
    n_tests++; if (s_out !== 1'b0) begin n_fail++; $display("FAIL rmid_sout: got %b want 0", s_out); end
    n_tests++; if (sync  !== 1'b0) begin n_fail++; $display("FAIL rmid_sync: got %b want 0", sync); end
    n_tests++; if (fdone !== 1'b0) begin n_fail++; $display("FAIL rmid_fdone: got %b want 0", fdone); end
    tick();
    tick();
    rstn = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if ({s_out, sync, fdone} !== 3'b000) bad++;
      tick();
    end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL rmid_quiet: got %0d active cycles want 0", bad); end
    n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL rmid_ready_after: got %b want 1", ready); end
  endtask

  task automatic test_loopback();
    logic [0:15] sent[$];
    logic [0:15] w;
    int          base_rx = rx_words.size();
    int          base_fd = fd_count;
    int          budget;
    for (int i = 0; i < 100; i++) begin
      w = 16'($urandom);
      sent.push_back(w);
      din  = w;
      send = 1'b1;
      budget = 0;
      while (ready !== 1'b1 && budget < 40) begin
        tick();
        budget++;
      end
      n_tests++;
      if (ready !== 1'b1) begin
        n_fail++; $display("FAIL lb_ready_timeout word%0d: got %b want 1", i, ready);
        break;
      end
      tick();
      send = 1'b0;
    end
    send = 1'b0;
    repeat (40) tick();
    n_tests++;
    if (rx_words.size() - base_rx != sent.size()) begin
      n_fail++; $display("FAIL lb_word_count: got %0d want %0d", rx_words.size() - base_rx, sent.size());
    end
    n_tests++;
    if (fd_count - base_fd != sent.size()) begin
      n_fail++; $display("FAIL lb_frame_done_count: got %0d want %0d", fd_count - base_fd, sent.size());
    end
    for (int i = 0; i < sent.size(); i++) begin
      if (base_rx + i < rx_words.size()) begin
        n_tests++;
        if (rx_words[base_rx + i] !== sent[i]) begin
          n_fail++; $display("FAIL lb_word%0d: got %h want %h", i, rx_words[base_rx + i], sent[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single(16'hA5C3, "single");
    test_back_to_back();
    test_ignore();
    test_reset_mid();
    test_single(16'h3C96, "post_rst");
    test_loopback();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
